// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter and the external ALU.
// Holds the op codes, the FSM state encoding and the counter-width helper.
// The ALU side imports this package so both ends agree on op encodings.
package alu_arbiter_pkg;

  localparam int OP_DIV = 0;
  localparam int OP_MUL = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The counter is sized for the longest op, plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// 2-way round-robin grant with a priority pointer.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   valid[1:0]  : request lines
//   en          : grants are only issued while enabled
//   update      : the current owner's transaction has completed
//   last        : index of that owner; the pointer moves to the other one
//   grant[1:0]  : one-hot (or zero) grant, combinational from valid
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       en,
  input  logic       update,
  input  logic       last,
  output logic [1:0] grant
);

  // ptr names the requester that wins a tie
  logic ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= 1'b0;
    else if (update) ptr <= ~last;
  end

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one multi-cycle external ALU.
// One transaction is in flight at a time: accept -> EXEC (fixed cycle count
// per op) -> RESP (hold result until the consumer takes it) -> IDLE.
// Ports:
//   Clock, Reset             : clock, asynchronous active-high reset
//   ReqN{Valid,Ready}        : request handshake, requester N
//   ReqN{Operation,A,B}      : op code and signed operands
//   Resp{Valid,Ready}        : response handshake
//   Resp{Id,R,Flags}         : owner, captured result and flags
//   Alu{Operation,A,B}       : registered operands to the external ALU
//   AluFlagsIn               : architectural flags fed to the ALU
//   Alu{R,FlagsOut}          : ALU outputs, sampled at the end of EXEC
//   Flags                    : architectural flag register
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int L          = 16,
  parameter int P          = 0,
  parameter int DIV_CYCLES = 4,
  parameter int MUL_CYCLES = 2
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Req0Valid,
  output logic         Req0Ready,
  input  logic [P:0]   Req0Operation,
  input  logic [L-1:0] Req0A,
  input  logic [L-1:0] Req0B,
  input  logic         Req1Valid,
  output logic         Req1Ready,
  input  logic [P:0]   Req1Operation,
  input  logic [L-1:0] Req1A,
  input  logic [L-1:0] Req1B,
  output logic         RespValid,
  input  logic         RespReady,
  output logic         RespId,
  output logic [L-1:0] RespR,
  output logic [L-1:0] RespFlags,
  output logic [P:0]   AluOperation,
  output logic [L-1:0] AluA,
  output logic [L-1:0] AluB,
  output logic [L-1:0] AluFlagsIn,
  input  logic [L-1:0] AluR,
  input  logic [L-1:0] AluFlagsOut,
  output logic [L-1:0] Flags
);

  localparam int CW = cnt_width(DIV_CYCLES, MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    grant;
  logic          accept, sel, hs;
  logic [P:0]    op_sel;
  logic [L-1:0]  a_sel, b_sel;

  // Ready is forced low while Reset is asserted so every output reads 0.
  rr_arbiter2 u_arb (
    .clk    (Clock),
    .rst    (Reset),
    .valid  ({Req1Valid, Req0Valid}),
    .en     ((state == ST_IDLE) && !Reset),
    .update (hs),
    .last   (RespId),
    .grant  (grant)
  );

  assign Req0Ready  = grant[0];
  assign Req1Ready  = grant[1];
  assign accept     = |grant;
  assign sel        = grant[1];
  assign hs         = (state == ST_RESP) && RespValid && RespReady;
  assign AluFlagsIn = Flags;

  assign op_sel = sel ? Req1Operation : Req0Operation;
  assign a_sel  = sel ? Req1A : Req0A;
  assign b_sel  = sel ? Req1B : Req0B;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      AluOperation <= '0;
      AluA         <= '0;
      AluB         <= '0;
      RespId       <= 1'b0;
      RespR        <= '0;
      RespFlags    <= '0;
      RespValid    <= 1'b0;
      Flags        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            AluOperation <= op_sel;
            AluA         <= a_sel;
            AluB         <= b_sel;
            RespId       <= sel;
            cnt          <= (op_sel == (P+1)'(OP_DIV)) ? DIV_LOAD : MUL_LOAD;
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            RespR     <= AluR;
            RespFlags <= AluFlagsOut;
            Flags     <= AluFlagsOut;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          // First RESP cycle only registers RespValid; the result is
          // already stable, so the consumer sees it settled for a full cycle.
          if (hs) begin
            RespValid <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            RespValid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0Valid = 1'b0, Req1Valid = 1'b0;
  logic        Req0Ready, Req1Ready;
  logic [0:0]  Req0Operation = '0, Req1Operation = '0;
  logic [15:0] Req0A = '0, Req0B = '0, Req1A = '0, Req1B = '0;
  logic        RespValid, RespId;
  logic        RespReady = 1'b1;
  logic [15:0] RespR, RespFlags;
  logic [0:0]  AluOperation;
  logic [15:0] AluA, AluB, AluFlagsIn, AluR, AluFlagsOut, Flags;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  alu_arbiter #(.L(16), .P(0), .DIV_CYCLES(4), .MUL_CYCLES(2)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Operation(Req0Operation),
    .Req0A(Req0A), .Req0B(Req0B),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Operation(Req1Operation),
    .Req1A(Req1A), .Req1B(Req1B),
    .RespValid(RespValid), .RespReady(RespReady), .RespId(RespId),
    .RespR(RespR), .RespFlags(RespFlags),
    .AluOperation(AluOperation), .AluA(AluA), .AluB(AluB), .AluFlagsIn(AluFlagsIn),
    .AluR(AluR), .AluFlagsOut(AluFlagsOut), .Flags(Flags)
  );

  always #5 Clock = ~Clock;

  // External ALU: flags bit0 zero, bit1 negative, bit2 divide-by-zero
  logic signed [15:0] sa, sb;
  logic signed [31:0] prod;
  logic dz;
  assign sa = AluA;
  assign sb = AluB;
  assign prod = sa * sb;
  always_comb begin
    dz   = 1'b0;
    AluR = '0;
    if (AluOperation == 1'(OP_MUL)) AluR = prod[15:0];
    else if (AluB == 16'd0) dz = 1'b1;
    else AluR = sa / sb;
    AluFlagsOut = {13'd0, dz, AluR[15], AluR == 16'd0};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Wait for RespValid after an accept edge; returns edges counted.
  task automatic wait_resp(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (RespValid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    // reset state, with a request pending to show Ready is held low
    Req0Valid = 1'b1;
    #12;
    chk("rst_ready0", Req0Ready, 0);
    chk("rst_respvalid", RespValid, 0);
    chk("rst_flags", Flags, 0);
    chk("rst_alu", {AluA, AluB}, 0);
    Req0Valid = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;

    // division 6/3 from requester 0
    Req0Valid = 1'b1; Req0Operation = 1'b0; Req0A = 16'd6; Req0B = 16'd3;
    #1;
    chk("div_ready0", Req0Ready, 1);
    chk("div_ready1", Req1Ready, 0);
    tick();
    Req0Valid = 1'b0;
    chk("div_alua", AluA, 6);
    wait_resp(lat);
    chk("div_latency", lat, 5);
    chk("div_r", RespR, 2);
    chk("div_id", RespId, 0);
    tick();
    chk("div_hs_done", RespValid, 0);
    chk("div_flags", Flags, 0);

    // pointer starts at 0 again after reset; grants alternate
    Reset = 1'b1; #2; Reset = 1'b0;
    Req0Valid = 1'b1; Req0Operation = 1'b1; Req0A = 16'd2; Req0B = 16'd3;
    Req1Valid = 1'b1; Req1Operation = 1'b1; Req1A = 16'd6; Req1B = 16'd6;
    #1;
    for (int t = 0; t < 4; t++) begin
      chk("alt_ready0", Req0Ready, (t % 2 == 0) ? 1 : 0);
      chk("alt_ready1", Req1Ready, (t % 2 == 1) ? 1 : 0);
      tick();
      wait_resp(lat);
      chk("mul_latency", lat, 3);
      chk("alt_id", RespId, (t % 2 == 0) ? 0 : 1);
      chk("alt_r", RespR, (t % 2 == 0) ? 6 : 36);
      tick();
    end
    Req0Valid = 1'b0; Req1Valid = 1'b0;

    // back-pressure: -2*5 from requester 1, RespReady low for 3 cycles
    RespReady = 1'b0;
    Req1Valid = 1'b1; Req1A = 16'hFFFE; Req1B = 16'd5;
    #1;
    chk("bp_ready1", Req1Ready, 1);
    tick();
    Req1Valid = 1'b0;
    Req0Valid = 1'b1; Req0Operation = 1'b1; Req0A = 16'd1; Req0B = 16'd1;
    wait_resp(lat);
    chk("bp_latency", lat, 3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", RespValid, 1);
      chk("bp_r", RespR, 16'hFFF6);
      chk("bp_flags", RespFlags, 16'h0002);
      chk("bp_id", RespId, 1);
      chk("bp_readies", {Req0Ready, Req1Ready}, 0);
      tick();
    end
    RespReady = 1'b1;
    #1;
    chk("bp_still_valid", RespValid, 1);
    tick();
    chk("bp_hs_done", RespValid, 0);
    chk("bp_arch_flags", Flags, 16'h0002);
    chk("bp_reaccept_ready", Req0Ready, 1);
    Req0Valid = 1'b0;
    tick();

    // divide by zero, then confirm the ALU sees those flags for the next op
    Req0Valid = 1'b1; Req0Operation = 1'b0; Req0A = 16'd6; Req0B = 16'd0;
    tick();
    Req0Valid = 1'b0;
    chk("dz_flags_unchanged_on_accept", Flags, 16'h0002);
    wait_resp(lat);
    chk("dz_r", RespR, 0);
    chk("dz_respflags", RespFlags, 16'h0005);
    tick();
    chk("dz_flags", Flags, 16'h0005);
    Req1Valid = 1'b1; Req1Operation = 1'b1; Req1A = 16'd1; Req1B = 16'hFFFF;
    tick();
    Req1Valid = 1'b0;
    chk("dz_next_flagsin_0", AluFlagsIn, 16'h0005);
    chk("dz_next_op", AluOperation, 1);
    tick();
    chk("dz_next_flagsin_1", AluFlagsIn, 16'h0005);
    wait_resp(lat);
    chk("neg_r", RespR, 16'hFFFF);
    tick();
    chk("neg_flags", Flags, 16'h0002);

    // reset in the 2nd EXEC cycle of a division
    Req0Valid = 1'b1; Req0Operation = 1'b0; Req0A = 16'd100; Req0B = 16'd7;
    tick();
    Req0Valid = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    chk("abort_flags", Flags, 0);
    chk("abort_alu", {AluOperation, AluA, AluB, AluFlagsIn}, 0);
    chk("abort_resp", {RespValid, RespId, RespR, RespFlags}, 0);
    chk("abort_ready", {Req0Ready, Req1Ready}, 0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_resp", RespValid, 0);
    end
    chk("abort_flags_after", Flags, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
